// File: rtl/isa_bus_pkg.sv
// Shared ISA bus constants: IRQ line indices and the IRQ controller register map.
// Also imported by SuperIO when wiring the irq_in vector.
package isa_bus_pkg;

    localparam int NUM_IRQ = 4;

    localparam int IRQ2_IDX  = 0;
    localparam int IRQ5_IDX  = 1;
    localparam int IRQ7_IDX  = 2;
    localparam int IRQ10_IDX = 3;

    typedef logic [NUM_IRQ-1:0] irq_vec_t;
    typedef logic [2:0]         reg_addr_t;

    localparam reg_addr_t REG_PENDING = 3'd0;
    localparam reg_addr_t REG_MASK    = 3'd1;
    localparam reg_addr_t REG_CLEAR   = 3'd2;
    localparam reg_addr_t REG_LEVEL   = 3'd3;
    localparam reg_addr_t REG_COUNT0  = 3'd4;

    // COUNT registers are laid out contiguously, one word per line.
    function automatic reg_addr_t count_addr(input int idx);
        return REG_COUNT0 + reg_addr_t'(idx);
    endfunction

endpackage

// File: rtl/isa_irq_filter.sv
// One ISA IRQ line: 2-flop synchroniser, stability glitch filter and rising-edge detect.
// The filtered level only changes after FILTER_CYCLES consecutive mismatching samples.
module isa_irq_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic sync_lvl,
    output logic filt_lvl,
    output logic rise
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            filt_q <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
            rise_q <= 1'b0;
            if (sync_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // Level accepted; a 0->1 acceptance is the one-cycle event.
                filt_q <= sync_q;
                rise_q <= sync_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign sync_lvl = sync_q;
    assign filt_lvl = filt_q;
    assign rise     = rise_q;

endmodule

// File: rtl/isa_irq_controller.sv
// ISA IRQ2/5/7/10 controller: filtered edge capture into PENDING, maskable HPS interrupt,
// saturating per-line event counters, all behind an Avalon-MM slave with registered reads.
module isa_irq_controller
    import isa_bus_pkg::*;
#(
    parameter int FILTER_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               write,
    input  logic               read,
    input  logic [2:0]         address,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               irq_hps
);

    irq_vec_t sync_lvl;
    irq_vec_t filt_lvl;
    irq_vec_t rise;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
        isa_irq_filter #(
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_filter (
            .clk     (clk),
            .reset   (reset),
            .raw     (irq_in[gi]),
            .sync_lvl(sync_lvl[gi]),
            .filt_lvl(filt_lvl[gi]),
            .rise    (rise[gi])
        );
    end

    irq_vec_t         pending_q, pending_d;
    irq_vec_t         mask_q, mask_d;
    logic [CNT_W-1:0] count_q [NUM_IRQ];
    logic [CNT_W-1:0] count_d [NUM_IRQ];
    logic [31:0]      readdata_q, readdata_d;
    logic [31:0]      rd_mux;
    logic             irq_hps_q, irq_hps_d;

    // Only the low NUM_IRQ data bits carry meaning for MASK and CLEAR.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:NUM_IRQ];

    always_comb begin
        pending_d = pending_q;
        mask_d    = mask_q;
        count_d   = count_q;

        if (write && address == REG_MASK) begin
            mask_d = writedata[NUM_IRQ-1:0];
        end
        if (write && address == REG_CLEAR) begin
            pending_d = pending_q & ~writedata[NUM_IRQ-1:0];
        end
        // Applied after the clear so a coincident event keeps its bit.
        pending_d = pending_d | rise;

        for (int i = 0; i < NUM_IRQ; i++) begin
            if (write && address == count_addr(i)) begin
                count_d[i] = rise[i] ? CNT_W'(1) : '0;
            end else if (rise[i] && count_q[i] != '1) begin
                count_d[i] = count_q[i] + 1'b1;
            end
        end

        irq_hps_d = |(pending_d & mask_d);
    end

    // Read mux looks at current state, so a same-cycle write is not yet visible.
    always_comb begin
        rd_mux = '0;
        case (address)
            REG_PENDING: rd_mux[NUM_IRQ-1:0]   = pending_q;
            REG_MASK:    rd_mux[NUM_IRQ-1:0]   = mask_q;
            REG_CLEAR:   rd_mux                = '0;
            REG_LEVEL:   rd_mux[2*NUM_IRQ-1:0] = {sync_lvl, filt_lvl};
            default:     rd_mux[CNT_W-1:0]     = count_q[address[1:0]];
        endcase
        readdata_d = read ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q  <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            irq_hps_q  <= 1'b0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_hps_q  <= irq_hps_d;
            count_q    <= count_d;
        end
    end

    assign readdata = readdata_q;
    assign irq_hps  = irq_hps_q;

endmodule

// File: tb/tb_isa_irq_controller.sv
// Directed bench for isa_irq_controller; read results go through an expected-value queue.
// Counter width is reduced so saturation is reachable in a short run.
module tb_isa_irq_controller;
    import isa_bus_pkg::*;

    localparam int FILT   = 8;
    localparam int TB_CNT = 8;
    localparam int SAT    = (1 << TB_CNT) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq_in = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq_hps;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    isa_irq_controller #(
        .FILTER_CYCLES(FILT),
        .CNT_W        (TB_CNT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .write    (write),
        .read     (read),
        .address  (address),
        .writedata(writedata),
        .readdata (readdata),
        .irq_hps  (irq_hps)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Scoreboard: expectation queued when the read is issued, popped when readdata is valid.
    task automatic rd(input logic [2:0] a, input logic [31:0] expv, input string tag);
        exp_t e;
        exp_q.push_back('{tag: tag, value: expv});
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        e = exp_q.pop_front();
        chk(readdata, e.value, e.tag);
        $display("read  addr=%0d data=%h (%s)", a, readdata, tag);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write = 1'b0;
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] expv,
                        input string tag);
        exp_t e;
        exp_q.push_back('{tag: tag, value: expv});
        address   = a;
        writedata = d;
        read      = 1'b1;
        write     = 1'b1;
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        e = exp_q.pop_front();
        chk(readdata, e.value, e.tag);
        $display("rdwr  addr=%0d wdata=%h rdata=%h (%s)", a, d, readdata, tag);
    endtask

    initial begin
        // 1: reset state
        repeat (3) @(negedge clk);
        chk(readdata, 32'h0, "rst_readdata");
        chk({31'b0, irq_hps}, 32'h0, "rst_irq_hps");
        reset = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'h0, "rst_read");
        end
        chk({31'b0, irq_hps}, 32'h0, "rst_irq_hps_after");

        // 2: IRQ5 latency, 11 cycles raw edge -> pending
        wr(REG_MASK, 32'hF);
        rd(REG_MASK, 32'hF, "mask_f");
        irq_in[IRQ5_IDX] = 1'b1;
        repeat (10) @(negedge clk);
        chk({31'b0, irq_hps}, 32'h0, "irq5_hps_early");
        rd(REG_PENDING, 32'h0, "irq5_pend_early");
        chk({31'b0, irq_hps}, 32'h1, "irq5_hps");
        rd(REG_PENDING, 32'h2, "irq5_pend");
        rd(count_addr(IRQ5_IDX), 32'h1, "irq5_count");
        rd(REG_LEVEL, 32'h22, "irq5_level");

        // 4: clear write coincident with a fresh IRQ5 event
        irq_in[IRQ5_IDX] = 1'b0;
        repeat (12) @(negedge clk);
        rd(REG_PENDING, 32'h2, "irq5_fall_ignored");
        irq_in[IRQ5_IDX] = 1'b1;
        repeat (10) @(negedge clk);
        wr(REG_CLEAR, 32'h2);
        rd(REG_PENDING, 32'h2, "set_beats_clear");
        rd(count_addr(IRQ5_IDX), 32'h2, "irq5_count2");
        wr(REG_CLEAR, 32'h2);
        chk({31'b0, irq_hps}, 32'h0, "clear_hps");
        rd(REG_PENDING, 32'h0, "clear_pend");

        // 3: short IRQ7 glitch rejected, then held pulse accepted
        irq_in[IRQ7_IDX] = 1'b1;
        repeat (5) @(negedge clk);
        irq_in[IRQ7_IDX] = 1'b0;
        repeat (12) @(negedge clk);
        rd(REG_PENDING, 32'h0, "glitch_pend");
        rd(REG_LEVEL, 32'h22, "glitch_level");
        rd(count_addr(IRQ7_IDX), 32'h0, "glitch_count");
        irq_in[IRQ7_IDX] = 1'b1;
        repeat (11) @(negedge clk);
        chk({31'b0, irq_hps}, 32'h1, "irq7_hps");
        rd(REG_PENDING, 32'h4, "irq7_pend");
        rd(REG_LEVEL, 32'h66, "irq7_level");
        rd(count_addr(IRQ7_IDX), 32'h1, "irq7_count");
        wr(REG_CLEAR, 32'h4);
        chk({31'b0, irq_hps}, 32'h0, "irq7_clear_hps");

        // 5: masked events on all lines, then unmask IRQ10 only
        rdwr(REG_MASK, 32'h0, 32'hF, "rdwr_prewrite");
        rd(REG_MASK, 32'h0, "mask_0");
        irq_in = 4'h0;
        repeat (12) @(negedge clk);
        irq_in = 4'hF;
        repeat (12) @(negedge clk);
        rd(REG_PENDING, 32'hF, "all_pend");
        chk({31'b0, irq_hps}, 32'h0, "masked_hps");
        wr(REG_MASK, 32'h8);
        chk({31'b0, irq_hps}, 32'h1, "unmask_hps");
        rd(count_addr(IRQ7_IDX), 32'h2, "irq7_count2");
        rd(count_addr(IRQ10_IDX), 32'h1, "irq10_count");
        wr(REG_CLEAR, 32'h8);
        chk({31'b0, irq_hps}, 32'h0, "clear8_hps");
        wr(REG_PENDING, 32'h0);
        wr(REG_LEVEL, 32'h0);
        rd(REG_PENDING, 32'h7, "ro_write_ignored");
        wr(REG_CLEAR, 32'hF);

        // 6: IRQ2 counter saturation and write/event collision
        irq_in[IRQ2_IDX] = 1'b0;
        repeat (12) @(negedge clk);
        wr(count_addr(IRQ2_IDX), 32'h0);
        rd(count_addr(IRQ2_IDX), 32'h0, "cnt_cleared");
        for (int n = 0; n < SAT + 1; n++) begin
            irq_in[IRQ2_IDX] = 1'b1;
            repeat (9) @(negedge clk);
            irq_in[IRQ2_IDX] = 1'b0;
            repeat (9) @(negedge clk);
        end
        rd(count_addr(IRQ2_IDX), 32'(SAT), "cnt_sat");
        irq_in[IRQ2_IDX] = 1'b1;
        repeat (9) @(negedge clk);
        irq_in[IRQ2_IDX] = 1'b0;
        repeat (9) @(negedge clk);
        rd(count_addr(IRQ2_IDX), 32'(SAT), "cnt_sat_hold");
        irq_in[IRQ2_IDX] = 1'b1;
        repeat (10) @(negedge clk);
        wr(count_addr(IRQ2_IDX), 32'hDEAD);
        rd(count_addr(IRQ2_IDX), 32'h1, "cnt_write_event");
        repeat (3) @(negedge clk);
        chk(readdata, 32'h1, "readdata_hold");
        rd(REG_PENDING, 32'h1, "irq2_pend");

        // 7: reset while IRQ10 filter is mid-count
        irq_in = 4'h0;
        repeat (12) @(negedge clk);
        wr(REG_CLEAR, 32'hF);
        rd(REG_MASK, 32'h8, "pre_reset_mask");
        irq_in[IRQ10_IDX] = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk(readdata, 32'h0, "midrst_readdata");
        chk({31'b0, irq_hps}, 32'h0, "midrst_hps");
        reset = 1'b1;
        rd(REG_MASK, 32'h0, "midrst_mask");
        rd(count_addr(IRQ10_IDX), 32'h0, "midrst_count");
        repeat (8) @(negedge clk);
        rd(REG_PENDING, 32'h0, "postrst_pend_early");
        rd(REG_PENDING, 32'h8, "postrst_pend");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
